// File: rtl/iob_timer_ctrl_pkg.sv
// Shared definitions for the programmable timer: FSM state encoding and mode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iob_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/iob_timer_prescaler.sv
// Prescaler: counts enabled cycles and wraps at div, flagging the wrap cycle as a strobe.
// Latency: strobe is combinational from the registered count (asserted in the cycle count==div).
// Backpressure: none; en gates counting, clear forces the count back to zero.
module iob_timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               rst_i,
  input  logic               clear,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  output logic               strobe
);

  logic [PRESC_W-1:0] cnt;

  assign strobe = en && (cnt == div);

  // Count enabled cycles, wrapping to zero on the strobe cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt <= '0;
    end else if (rst_i || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= strobe ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iob_timer_ctrl.sv
// Timer controller: start/stop FSM, prescaled up-counter, terminal-count tick and sticky irq.
// Latency: tick_o/irq_o registered one cycle after the expiry strobe; busy_o one cycle after start.
// Backpressure: none; start ignored while running, stop beats start. Macro IOB_TIMER_CTRL_SNAPSHOT_EN adds snap_i/snap_o.
module iob_timer_ctrl
  import iob_timer_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
  input  logic [DATA_W-1:0]  period_i,
  input  logic [PRESC_W-1:0] prescale_i,
  input  logic               irq_clr_i,
  output logic [DATA_W-1:0]  count_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               tick_o,
  output logic               irq_o
`ifdef IOB_TIMER_CTRL_SNAPSHOT_EN
  ,
  input  logic               snap_i,
  output logic [DATA_W-1:0]  snap_o
`endif
);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  period_r, count_r, count_nxt;
  logic [PRESC_W-1:0] prescale_r;
  logic               mode_r;
  logic               tick_nxt, irq_nxt, load, presc_clr, strobe;

  assign count_o = count_r;
  assign busy_o  = (state == RUN);
  assign done_o  = (state == DONE);

  iob_timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .rst_i (rst_i),
    .clear (presc_clr),
    .en    (state == RUN),
    .div   (prescale_r),
    .strobe(strobe)
  );

  // State, count, pulse/flag and latched settings registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state      <= IDLE;
      count_r    <= '0;
      tick_o     <= 1'b0;
      irq_o      <= 1'b0;
      period_r   <= '0;
      prescale_r <= '0;
      mode_r     <= MODE_ONESHOT;
    end else if (rst_i) begin
      state      <= IDLE;
      count_r    <= '0;
      tick_o     <= 1'b0;
      irq_o      <= 1'b0;
      period_r   <= '0;
      prescale_r <= '0;
      mode_r     <= MODE_ONESHOT;
    end else begin
      state   <= state_nxt;
      count_r <= count_nxt;
      tick_o  <= tick_nxt;
      irq_o   <= irq_nxt;
      if (load) begin
        period_r   <= period_i;
        prescale_r <= prescale_i;
        mode_r     <= mode_i;
      end
    end
  end

  // Next-state, count and expiry decisions; stop always takes priority over start and expiry.
  always_comb begin
    state_nxt = state;
    count_nxt = count_r;
    tick_nxt  = 1'b0;
    irq_nxt   = irq_clr_i ? 1'b0 : irq_o;
    load      = 1'b0;
    presc_clr = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (stop_i) begin
          state_nxt = IDLE;
        end else if (start_i) begin
          load      = 1'b1;
          count_nxt = '0;
          presc_clr = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_nxt = IDLE;
          presc_clr = 1'b1;
        end else if (strobe) begin
          if (count_r == period_r) begin
            tick_nxt = 1'b1;
            irq_nxt  = 1'b1;
            if (mode_r == MODE_PERIODIC) begin
              count_nxt = '0;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            count_nxt = count_r + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef IOB_TIMER_CTRL_SNAPSHOT_EN
  // Capture the live count on request; holds between requests.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      snap_o <= '0;
    end else if (rst_i) begin
      snap_o <= '0;
    end else if (snap_i) begin
      snap_o <= count_r;
    end
  end
`endif

endmodule

// File: doc/iob_timer_ctrl.md
Name: iob_timer_ctrl

Overview:
Programmable timer controller that sequences a free-running up-counter with a prescaler, a terminal-count compare and start/stop control. It supports one-shot and periodic modes and produces a per-period tick pulse plus a sticky interrupt. It sits between a CSR block, which drives the config/command inputs, and any logic that needs periodic events: watchdogs, sample timers, timeouts.

Parameters:
DATA_W, 32, width of period register and count_o
PRESC_W, 16, width of prescale register and internal prescaler counter

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous active-high reset
rst_i  in  1  synchronous reset; same effect as arst_i, applied on the clock edge
start_i  in  1  start command pulse
stop_i  in  1  stop command pulse
mode_i  in  1  0 = one-shot, 1 = periodic; sampled on accepted start
period_i  in  DATA_W  terminal count; sampled on accepted start
prescale_i  in  PRESC_W  prescale divisor minus 1; sampled on accepted start
irq_clr_i  in  1  clears irq_o
count_o  out  DATA_W  current count
busy_o  out  1  high in RUN
done_o  out  1  high in DONE (one-shot finished)
tick_o  out  1  one-cycle pulse at each period expiry
irq_o  out  1  sticky expiry flag

Behaviour:
- Reset (arst_i or rst_i):
  - state IDLE; count_o, busy_o, done_o, tick_o, irq_o all 0.
  - Internal period_r, prescale_r, mode_r and prescaler counter all 0.
- States: IDLE, RUN, DONE. busy_o = (state==RUN); done_o = (state==DONE). Both are registered.
- Start acceptance:
  - start_i is accepted in IDLE or DONE only.
  - On the accepting edge: latch period_i, prescale_i, mode_i; count_o<=0; prescaler<=0; state<=RUN.
  - start_i in RUN is ignored; config changes during RUN have no effect.
- RUN, each cycle:
  - If prescaler==prescale_r: prescaler<=0 and a strobe is generated. Otherwise prescaler increments.
  - On strobe with count_o!=period_r: count_o increments by 1.
- Expiry = strobe with count_o==period_r. On that edge:
  - tick_o<=1 for exactly one cycle; irq_o<=1.
  - Periodic: count_o<=0, stay in RUN.
  - One-shot: count_o holds period_r, state<=DONE.
- Period length = (period_r+1)*(prescale_r+1) cycles. First tick is registered high in the cycle after the ((period_r+1)*(prescale_r+1))-th RUN cycle.
- Boundary cases:
  - period_r=0: tick on every strobe; count_o stays 0.
  - prescale_r=0: strobe every RUN cycle.
  - Maximum values: no overflow, because count_o never exceeds period_r.
- stop_i in RUN: state<=IDLE; count_o holds its value; prescaler<=0; no tick, even if expiry coincides. stop_i in IDLE or DONE: moves DONE to IDLE, otherwise no effect.
- start_i and stop_i in the same cycle: stop wins, start is dropped.
- irq_clr_i clears irq_o. If an expiry sets irq in the same cycle, set wins.
- tick_o is 0 in every cycle with no expiry, including the cycle after stop or reset.
- Reset during RUN: immediate return to IDLE with all reset values. A pending tick is discarded.

Optional Feature:
IOB_TIMER_CTRL_SNAPSHOT_EN
- Defined:
  - Adds input snap_i (1 bit) and output snap_o (DATA_W bits).
  - When snap_i is high, snap_o<=count_o on that edge, so snap_o shows the value in the next cycle.
  - snap_o holds between snapshots; reset value 0; works in any state.
- Undefined: snap_i and snap_o ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package iob_timer_ctrl_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - mode constants: MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- One natural sub-module: iob_timer_prescaler (params PRESC_W).
  - Inputs: clk_i, arst_i, rst_i, clear, en, div.
  - Output: strobe.
  - Registered counter with wrap at div.
- FSM, compare, count and irq logic live in the top module.

Test Plan:
- Periodic, period=3, prescale=1, start pulse → busy_o=1 next cycle; tick_o pulses every 8 cycles; count_o sequence 0,0,1,1,2,2,3,3 repeating; irq_o=1 after first tick.
- One-shot, period=2, prescale=0 → tick_o once 3 cycles after RUN entry; done_o=1, busy_o=0, count_o=2 held; a new start returns to RUN with count_o=0.
- period=0, prescale=0, periodic → tick_o high every cycle in RUN, count_o=0 throughout; stop_i → tick_o=0 next cycle, state IDLE.
- start_i and stop_i together in IDLE → remains IDLE. Expiry cycle coinciding with stop_i → no tick. irq_clr_i coinciding with expiry → irq_o stays 1.
- arst_i asserted mid-RUN (count_o=5) → all outputs 0 immediately (asynchronously); after release, idle until start. rst_i gives the same result on the next edge.
- With IOB_TIMER_CTRL_SNAPSHOT_EN: snap_i when count_o=7 → snap_o=7 next cycle, held while count continues.
